// File: rtl/rf_write_arbiter.sv
// Writeback arbiter: two 1-entry holding buffers (ALU, MEM) drained round-robin into a registered GPR write port.
// Optional build macro ARB_FIXED_PRIO_EN: MEM (requester 1) wins contention instead of round-robin.
module rf_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [4:0]        req0_rd,
  input  logic [1:0]        req0_ctrl,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [4:0]        req1_rd,
  input  logic [1:0]        req1_ctrl,
  input  logic [DATA_W-1:0] req1_data,
  output logic              wr_en,
  output logic [4:0]        wr_rd,
  output logic [1:0]        wr_ctrl,
  output logic [DATA_W-1:0] wr_data,
  output logic [NREGS-1:0]  pending,
  output logic              bad_addr
);

  logic              buf0_valid_r, buf1_valid_r;
  logic [4:0]        buf0_rd_r, buf1_rd_r;
  logic [1:0]        buf0_ctrl_r, buf1_ctrl_r;
  logic [DATA_W-1:0] buf0_data_r, buf1_data_r;
  logic              age_r;  // 1: buf1 holds the older entry
  logic              pick1_s, grant0_s, grant1_s, load0_s, load1_s;
  logic [4:0]        sel_rd_s;
  logic [1:0]        sel_ctrl_s;
  logic [DATA_W-1:0] sel_data_s;

`ifdef ARB_FIXED_PRIO_EN
`else
  logic              last_grant_r;

  // Round-robin pointer: remembers which requester was granted last
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_r <= 1'b1;
    end else if (grant0_s) begin
      last_grant_r <= 1'b0;
    end else if (grant1_s) begin
      last_grant_r <= 1'b1;
    end
  end
`endif

  // Grant selection; same-rd age ordering overrides the pointer/priority
  always_comb begin
    if (buf0_rd_r == buf1_rd_r) begin
      pick1_s = age_r;
    end else begin
`ifdef ARB_FIXED_PRIO_EN
      pick1_s = 1'b1;
`else
      pick1_s = ~last_grant_r;
`endif
    end
    if (buf0_valid_r && buf1_valid_r) begin
      grant0_s = ~pick1_s;
      grant1_s = pick1_s;
    end else begin
      grant0_s = buf0_valid_r;
      grant1_s = buf1_valid_r;
    end
  end

  // Granted-entry mux feeding the port stage
  always_comb begin
    if (grant1_s) begin
      sel_rd_s   = buf1_rd_r;
      sel_ctrl_s = buf1_ctrl_r;
      sel_data_s = buf1_data_r;
    end else begin
      sel_rd_s   = buf0_rd_r;
      sel_ctrl_s = buf0_ctrl_r;
      sel_data_s = buf0_data_r;
    end
  end

  assign req0_ready = ~buf0_valid_r | grant0_s;
  assign req1_ready = ~buf1_valid_r | grant1_s;
  assign load0_s    = req0_valid & req0_ready;
  assign load1_s    = req1_valid & req1_ready;

  // Holding buffers and the relative-age flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf0_valid_r <= 1'b0;
      buf0_rd_r    <= 5'd0;
      buf0_ctrl_r  <= 2'd0;
      buf0_data_r  <= {DATA_W{1'b0}};
      buf1_valid_r <= 1'b0;
      buf1_rd_r    <= 5'd0;
      buf1_ctrl_r  <= 2'd0;
      buf1_data_r  <= {DATA_W{1'b0}};
      age_r        <= 1'b0;
    end else begin
      if (load0_s) begin
        buf0_valid_r <= 1'b1;
        buf0_rd_r    <= req0_rd;
        buf0_ctrl_r  <= req0_ctrl;
        buf0_data_r  <= req0_data;
      end else if (grant0_s) begin
        buf0_valid_r <= 1'b0;
      end
      if (load1_s) begin
        buf1_valid_r <= 1'b1;
        buf1_rd_r    <= req1_rd;
        buf1_ctrl_r  <= req1_ctrl;
        buf1_data_r  <= req1_data;
      end else if (grant1_s) begin
        buf1_valid_r <= 1'b0;
      end
      // buf1 becomes older only when buf0 reloads behind a surviving buf1 entry
      if (load0_s && !load1_s && buf1_valid_r && !grant1_s) begin
        age_r <= 1'b1;
      end else if (load0_s || load1_s) begin
        age_r <= 1'b0;
      end
    end
  end

  // Registered write port; out-of-range destinations are swallowed and flagged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en    <= 1'b0;
      wr_rd    <= 5'd0;
      wr_ctrl  <= 2'd0;
      wr_data  <= {DATA_W{1'b0}};
      bad_addr <= 1'b0;
    end else if (grant0_s || grant1_s) begin
      if (sel_rd_s[4]) begin
        wr_en    <= 1'b0;
        bad_addr <= 1'b1;
      end else begin
        wr_en   <= 1'b1;
        wr_rd   <= sel_rd_s;
        wr_ctrl <= sel_ctrl_s;
        wr_data <= sel_data_s;
      end
    end else begin
      wr_en <= 1'b0;
    end
  end

  // Pending-write bitmap from registered state only
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      pending[i] = (buf0_valid_r && !buf0_rd_r[4] && (buf0_rd_r[3:0] == 4'(i))) |
                   (buf1_valid_r && !buf1_rd_r[4] && (buf1_rd_r[3:0] == 4'(i))) |
                   (wr_en && (wr_rd[3:0] == 4'(i)));
    end
  end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the single write port of the 16-entry GPR file between two writeback requesters: req 0 is ALU/EX and req 1 is MEM/load.
- Each requester has a 1-entry holding buffer with a valid/ready handshake.
- A round-robin arbiter drains the buffers into a registered write port that carries the full, LCL and LCH write modes.
- Exports a pending-write bitmap that hazard logic uses to stall readers.

Parameters:
- DATA_W, 32, GPR data width.
- NREGS, 16, number of architected GPRs; the pending bitmap width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req0_valid  in  1  requester 0 has a write
- req0_ready  out  1  requester 0 buffer can accept this cycle
- req0_rd  in  5  destination register
- req0_ctrl  in  2  write mode: 00 full, 01 LCL (low half), 10 LCH (high half), 11 reserved, treated as full
- req0_data  in  DATA_W  write data
- req1_valid, req1_ready, req1_rd, req1_ctrl, req1_data: same as req0_* for requester 1
- wr_en  out  1  register-file write strobe
- wr_rd  out  5  register-file destination
- wr_ctrl  out  2  register-file write mode, same encoding as reqN_ctrl
- wr_data  out  DATA_W  register-file write data
- pending  out  NREGS  bit r=1 while any write to r is buffered or on the port
- bad_addr  out  1  sticky flag: a request with rd >= NREGS was seen

Behaviour:
- Reset (async, rst=1):
  - Both buffers invalid.
  - wr_en=0; wr_rd, wr_ctrl, wr_data = 0.
  - bad_addr=0.
  - RR pointer last_grant=1, so requester 0 wins the first contention.
  - Age flag cleared.
- Reset mid-operation discards all buffered writes; nothing reaches the port.
- Accept:
  - reqN_ready = ~bufN_valid | grantN (combinational); a buffer being drained can reload in the same cycle.
  - On an edge with reqN_valid & reqN_ready, bufN captures rd, ctrl and data and becomes valid.
- Grant (combinational, one per cycle, only among valid buffers):
  - Exactly one valid buffer: grant it.
  - Both valid, same rd: grant the older entry (age flag). If both were loaded on the same edge, requester 0 is older. This preserves write order per register.
  - Both valid, different rd: grant the requester that is not last_grant. last_grant updates on every grant.
- Port stage (registered):
  - On the edge after a grant, wr_* take the granted entry and wr_en=1 for exactly one cycle.
  - With no grant, wr_en=0 on the next edge. wr_rd, wr_ctrl, wr_data hold their values.
- Latency: accept at edge N, wr_en high after edge N+1, register file writes at edge N+2. With no contention, each requester sustains 1 write/cycle.
- Invalid address:
  - A granted entry with rd[4]=1 is consumed as normal but produces wr_en=0.
  - It sets bad_addr, which stays set until rst.
  - It never sets a pending bit.
- Pending bitmap:
  - pending = decode(buf0.rd) if buf0 valid | decode(buf1.rd) if buf1 valid | decode(wr_rd) if wr_en.
  - Combinational from registered state; no glitch from inputs.
- Width rules:
  - Data and ctrl pass through unmodified; the register file does the LCL/LCH merge.
  - Only rd[3:0] indexes pending.

Optional Feature:
- Macro ARB_FIXED_PRIO_EN.
- Defined: requester 1 (MEM) always wins when both buffers are valid. The same-rd age rule still overrides priority. The last_grant register is not implemented.
- Undefined: round-robin as specified above.

Test Plan:
- Single write: req0 valid, rd=3, ctrl=00, data=0xDEADBEEF, one cycle. Expect wr_en=1 with rd=3, data=0xDEADBEEF exactly 2 edges after the accept edge; pending[3]=1 from the accept edge until wr_en drops.
- Contention, different rd: req0 rd=1, req1 rd=2, presented simultaneously and held for 4 cycles with new data each cycle. Expect the port order 1,2,1,2,… with a 1-write/cycle aggregate. With ARB_FIXED_PRIO_EN, expect req1 drained first each time.
- Same rd ordering: req1 rd=5 data=0x1 accepted one cycle before req0 rd=5 data=0x2. Expect 0x1 written before 0x2 regardless of pointer or priority macro.
- LCL/LCH pass-through: req0 rd=7 ctrl=01 data=0x1234, then ctrl=10 data=0xABCD. Expect wr_ctrl 01 then 10 with data unmodified.
- Backpressure: req0 valid continuously while req1 is also continuously valid. Expect req0_ready high only on cycles where buf0 is empty or granted, and no request dropped or duplicated.
- Bad address and reset: req0 rd=20 accepted. Expect no wr_en pulse and bad_addr=1 sticky. Then assert rst with both buffers full: wr_en, pending and bad_addr go to 0 immediately and no write appears after rst is released.
